// File: rtl/csr_intr_unit.sv
// csr_intr_unit: machine-mode CSR file and external interrupt controller.
//   Synchronizes an asynchronous interrupt line, latches a pending request on
//   its rising edge and gates it with mstatus.MIE. Holds mstatus (MIE/MPIE),
//   mtvec, mepc and mcause. Trap entry, mret and CSR writes update them.
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   INTR_IN       asynchronous external interrupt request
//   INT_TAKEN     trap-entry pulse from the control FSM
//   CSR_WRITE     CSR write strobe; CSR_ADDR/CSR_WD select the target and data
//   MRET_EXEC     mret pulse
//   PC            resume address saved into mepc on trap entry
//   CSR_RD        combinational read data for CSR_ADDR
//   MTVEC, MEPC   register outputs to the PC mux
//   INTR          interrupt request (PENDING & MIE) to the control FSM
module csr_intr_unit #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR_IN,
  input  logic        INT_TAKEN,
  input  logic        CSR_WRITE,
  input  logic        MRET_EXEC,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WD,
  input  logic [31:0] PC,
  output logic [31:0] CSR_RD,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC,
  output logic        INTR
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;

  localparam logic [AW-1:0]   ADDR_MSTATUS = 12'h300;
  localparam logic [AW-1:0]   ADDR_MTVEC   = 12'h305;
  localparam logic [AW-1:0]   ADDR_MEPC    = 12'h341;
  localparam logic [AW-1:0]   ADDR_MCAUSE  = 12'h342;
  localparam logic [XLEN-1:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pending_q, pending_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic [XLEN-1:0]        mtvec_q, mtvec_d;
  logic [XLEN-1:0]        mepc_q, mepc_d;
  logic [XLEN-1:0]        mcause_q, mcause_d;
  logic                   sync_rise;
  logic [XLEN-1:0]        mstatus_val;

  // Synchronizer shift, edge detect and pending latch.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], INTR_IN};
    edge_d    = sync_q[SYNC_STAGES-1];
    sync_rise = sync_q[SYNC_STAGES-1] & ~edge_q;
    pending_d = pending_q;
    // A fresh edge beats the clear from INT_TAKEN so the new request survives.
    if (sync_rise) begin
      pending_d = 1'b1;
    end else if (INT_TAKEN) begin
      pending_d = 1'b0;
    end
  end

  // CSR updates: trap entry > mret > CSR write, lower ones dropped entirely.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (INT_TAKEN) begin
      mepc_d   = PC & ALIGN_MASK;
      mcause_d = CAUSE_EXT;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (MRET_EXEC) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (CSR_WRITE) begin
      unique case (CSR_ADDR)
        ADDR_MSTATUS: begin
          mie_d  = CSR_WD[3];
          mpie_d = CSR_WD[7];
        end
        ADDR_MTVEC:  mtvec_d  = CSR_WD & ALIGN_MASK;
        ADDR_MEPC:   mepc_d   = CSR_WD & ALIGN_MASK;
        ADDR_MCAUSE: mcause_d = CSR_WD;
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Read mux; shows the stored (pre-write) value during a write cycle.
  always_comb begin
    mstatus_val    = '0;
    mstatus_val[3] = mie_q;
    mstatus_val[7] = mpie_q;
    CSR_RD         = '0;
    unique case (CSR_ADDR)
      ADDR_MSTATUS: CSR_RD = mstatus_val;
      ADDR_MTVEC:   CSR_RD = mtvec_q;
      ADDR_MEPC:    CSR_RD = mepc_q;
      ADDR_MCAUSE:  CSR_RD = mcause_q;
      default:      CSR_RD = '0;
    endcase
  end

  assign MTVEC = mtvec_q;
  assign MEPC  = mepc_q;
  assign INTR  = pending_q & mie_q;

endmodule

// File: tb/tb_csr_intr_unit.sv
// Directed bench for csr_intr_unit: inputs change 1 ns after each rising edge,
// outputs are sampled a few ns later, well before the next edge.
module tb_csr_intr_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INTR_IN;
  logic        INT_TAKEN;
  logic        CSR_WRITE;
  logic        MRET_EXEC;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WD;
  logic [31:0] PC;
  logic [31:0] CSR_RD;
  logic [31:0] MTVEC;
  logic [31:0] MEPC;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  csr_intr_unit #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .INTR_IN(INTR_IN), .INT_TAKEN(INT_TAKEN),
    .CSR_WRITE(CSR_WRITE), .MRET_EXEC(MRET_EXEC), .CSR_ADDR(CSR_ADDR),
    .CSR_WD(CSR_WD), .PC(PC), .CSR_RD(CSR_RD), .MTVEC(MTVEC), .MEPC(MEPC),
    .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    CSR_ADDR = addr;
    #1;
    chk(tag, CSR_RD, exp);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    CSR_WRITE = 1'b1;
    CSR_ADDR  = addr;
    CSR_WD    = data;
    tick();
    CSR_WRITE = 1'b0;
  endtask

  initial begin
    int rises;
    logic prev;
    logic taken;

    RST = 1'b1; INTR_IN = 1'b0; INT_TAKEN = 1'b0; CSR_WRITE = 1'b0;
    MRET_EXEC = 1'b0; CSR_ADDR = '0; CSR_WD = '0; PC = '0;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    chk("rst_intr", 32'(INTR), 32'h0);
    chk("rst_mtvec", MTVEC, 32'h0);
    chk("rst_mepc", MEPC, 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mcause", 12'h342, 32'h0);

    // mtvec write with alignment; read shows old value in the write cycle
    CSR_WRITE = 1'b1; CSR_ADDR = 12'h305; CSR_WD = 32'h0000_1003;
    #1;
    chk("mtvec_prewrite", CSR_RD, 32'h0);
    tick();
    CSR_WRITE = 1'b0;
    chk("mtvec_out", MTVEC, 32'h0000_1000);
    rd_chk("mtvec_rd", 12'h305, 32'h0000_1000);

    // Unimplemented address: write ignored, read zero
    csr_wr(12'h123, 32'hFFFF_FFFF);
    rd_chk("unimpl_rd", 12'h123, 32'h0);
    chk("unimpl_mtvec", MTVEC, 32'h0000_1000);

    // mcause full width, mstatus masking
    csr_wr(12'h342, 32'h1234_5677);
    rd_chk("mcause_rd", 12'h342, 32'h1234_5677);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    rd_chk("mstatus_mask", 12'h300, 32'h0000_0088);
    csr_wr(12'h300, 32'h0000_0008);
    rd_chk("mstatus_mie", 12'h300, 32'h0000_0008);

    // Interrupt latency: INTR high exactly 3 edges after INTR_IN rises
    INTR_IN = 1'b1;
    tick(); chk("lat_c1", 32'(INTR), 32'h0);
    tick(); chk("lat_c2", 32'(INTR), 32'h0);
    tick(); chk("lat_c3", 32'(INTR), 32'h1);
    INTR_IN = 1'b0;

    // Trap entry
    INT_TAKEN = 1'b1; PC = 32'h0000_0124;
    tick();
    INT_TAKEN = 1'b0;
    chk("trap_mepc", MEPC, 32'h0000_0124);
    rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
    rd_chk("trap_mstatus", 12'h300, 32'h0000_0080);
    chk("trap_intr", 32'(INTR), 32'h0);

    // mret restores MIE from MPIE
    MRET_EXEC = 1'b1;
    tick();
    MRET_EXEC = 1'b0;
    rd_chk("mret_mstatus", 12'h300, 32'h0000_0088);
    chk("mret_intr", 32'(INTR), 32'h0);

    // Held-high INTR_IN: one request only; take it and return while held
    INTR_IN = 1'b1; PC = 32'h0000_0200;
    rises = 0; prev = 1'b0; taken = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
      if (INTR && !prev) rises++;
      if (INTR && !taken) begin
        INT_TAKEN = 1'b1;
        taken = 1'b1;
      end else if (taken && i > 0 && dut.mie_q == 1'b0) begin
        MRET_EXEC = 1'b1;
      end
      prev = INTR;
    end
    INT_TAKEN = 1'b0; MRET_EXEC = 1'b0; INTR_IN = 1'b0;
    chk("held_rises", 32'(rises), 32'd1);
    chk("held_mepc", MEPC, 32'h0000_0200);
    rd_chk("held_mstatus", 12'h300, 32'h0000_0088);

    // MIE=0: request held pending, INTR follows MIE set
    csr_wr(12'h300, 32'h0);
    INTR_IN = 1'b1;
    tick(); tick(); tick(); tick();
    INTR_IN = 1'b0;
    chk("mie0_intr", 32'(INTR), 32'h0);
    CSR_WRITE = 1'b1; CSR_ADDR = 12'h300; CSR_WD = 32'h0000_0008;
    #1;
    chk("mie_wr_cycle", 32'(INTR), 32'h0);
    tick();
    CSR_WRITE = 1'b0;
    chk("mie1_intr", 32'(INTR), 32'h1);

    // INT_TAKEN beats a simultaneous mepc write
    INT_TAKEN = 1'b1; PC = 32'h0000_1237;
    CSR_WRITE = 1'b1; CSR_ADDR = 12'h341; CSR_WD = 32'hFFFF_FFFF;
    tick();
    INT_TAKEN = 1'b0; CSR_WRITE = 1'b0;
    chk("prio_mepc", MEPC, 32'h0000_1234);
    rd_chk("prio_mcause", 12'h342, 32'h8000_000B);
    chk("prio_intr", 32'(INTR), 32'h0);

    // mret beats a simultaneous mstatus write
    MRET_EXEC = 1'b1;
    CSR_WRITE = 1'b1; CSR_ADDR = 12'h300; CSR_WD = 32'h0;
    tick();
    MRET_EXEC = 1'b0; CSR_WRITE = 1'b0;
    rd_chk("prio_mret", 12'h300, 32'h0000_0088);

    // Edge and INT_TAKEN in the same cycle: pending survives
    INTR_IN = 1'b1;
    tick(); tick();
    INT_TAKEN = 1'b1;
    tick();
    INT_TAKEN = 1'b0; INTR_IN = 1'b0;
    chk("coinc_intr_mie0", 32'(INTR), 32'h0);
    rd_chk("coinc_mstatus", 12'h300, 32'h0000_0080);
    MRET_EXEC = 1'b1;
    tick();
    MRET_EXEC = 1'b0;
    chk("coinc_pending", 32'(INTR), 32'h1);

    // Reset with PENDING=1, MIE=1 and a simultaneous write
    RST = 1'b1;
    CSR_WRITE = 1'b1; CSR_ADDR = 12'h305; CSR_WD = 32'h0000_ABCD;
    tick();
    RST = 1'b0; CSR_WRITE = 1'b0;
    chk("rst2_intr", 32'(INTR), 32'h0);
    chk("rst2_mtvec", MTVEC, 32'h0);
    chk("rst2_mepc", MEPC, 32'h0);
    rd_chk("rst2_mstatus", 12'h300, 32'h0);
    rd_chk("rst2_mtvec_rd", 12'h305, 32'h0);
    rd_chk("rst2_mepc_rd", 12'h341, 32'h0);
    rd_chk("rst2_mcause", 12'h342, 32'h0);

    // Pending cleared by reset stays cleared once MIE is enabled
    csr_wr(12'h300, 32'h0000_0008);
    tick();
    chk("rst2_no_pending", 32'(INTR), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
